// File: rtl/mmio_pkg.sv
// Shared address map, region select encoding and address decoder for the
// RiSC-16 memory-mapped data bus.
package mmio_pkg;

   localparam logic [15:0] OUT_BASE = 16'hFFFF;
   localparam logic [15:0] IN_BASE  = 16'hFFF7;
   localparam logic [15:0] TMR_CNT  = 16'hFFE0;
   localparam logic [15:0] TMR_CMP  = 16'hFFE1;
   localparam logic [15:0] TMR_STAT = 16'hFFE2;

   typedef enum logic [2:0] {
      SEL_NONE = 3'd0,
      SEL_RAM  = 3'd1,
      SEL_OUT  = 3'd2,
      SEL_IN   = 3'd3,
      SEL_TMR  = 3'd4
   } sel_e;

   typedef struct packed {
      sel_e       sel;
      logic [2:0] idx;
   } dec_t;

   // OUT/IN ports count downward from their base, so the index is base - addr.
   function automatic dec_t mmio_decode(input logic [15:0] addr,
                                        input int          ram_bits,
                                        input int          out_num,
                                        input int          in_num,
                                        input logic        tmr_en);
      dec_t        d;
      logic [15:0] off_out;
      logic [15:0] off_in;
      d.sel   = SEL_NONE;
      d.idx   = '0;
      off_out = OUT_BASE - addr;
      off_in  = IN_BASE - addr;
      if ((addr >> ram_bits) == 16'd0) begin
         d.sel = SEL_RAM;
      end else if (off_out < 16'(out_num)) begin
         d.sel = SEL_OUT;
         d.idx = off_out[2:0];
      end else if ((addr <= IN_BASE) && (off_in < 16'(in_num))) begin
         d.sel = SEL_IN;
         d.idx = off_in[2:0];
      end else if (tmr_en && (addr >= TMR_CNT) && (addr <= TMR_STAT)) begin
         d.sel = SEL_TMR;
         d.idx = 3'(addr - TMR_CNT);
      end
      return d;
   endfunction

endpackage

// File: rtl/mmio_timer.sv
// Free-running 16-bit cycle counter with compare register and sticky match
// flag; present only in builds with MMIO_TIMER_EN.
module mmio_timer
   import mmio_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_wr_cnt,
   input  logic        i_wr_cmp,
   input  logic        i_wr_stat,
   input  logic [15:0] i_wr_data,
   output logic [15:0] o_cnt,
   output logic [15:0] o_cmp,
   output logic        o_match
);

   logic [15:0] cnt_q, cnt_d;
   logic [15:0] cmp_q, cmp_d;
   logic        match_q, match_d;
   logic        clr;

   // Compare on next-state values so the flag rises on the edge CNT reaches CMP;
   // a simultaneous clear loses to the set.
   always_comb begin
      cnt_d   = i_wr_cnt ? i_wr_data : cnt_q + 16'd1;
      cmp_d   = i_wr_cmp ? i_wr_data : cmp_q;
      clr     = i_wr_stat && i_wr_data[0];
      match_d = (cnt_d == cmp_d) || (match_q && !clr);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q   <= 16'h0000;
         cmp_q   <= 16'hFFFF;
         match_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         cmp_q   <= cmp_d;
         match_q <= match_d;
      end
   end

   assign o_cnt   = cnt_q;
   assign o_cmp   = cmp_q;
   assign o_match = match_q;

endmodule

// File: rtl/mmio_bus.sv
// Data-bus controller: decodes core accesses into RAM, output registers,
// synchronised inputs and (with MMIO_TIMER_EN defined) a cycle timer.
module mmio_bus
   import mmio_pkg::*;
#(
   parameter int p_WORD_LEN      = 16,
   parameter int p_DATA_ADDR_LEN = 10,
   parameter int p_OUT_NUM       = 4,
   parameter int p_IN_NUM        = 2
) (
   input  logic                            i_clk,
   input  logic                            i_rst_n,
   input  logic [15:0]                     i_addr,
   input  logic [p_WORD_LEN-1:0]           i_wr_data,
   input  logic                            i_wr_en,
   output logic [p_WORD_LEN-1:0]           o_rd_data,
   output logic [p_DATA_ADDR_LEN-1:0]      o_ram_addr,
   output logic                            o_ram_wr_en,
   output logic [p_WORD_LEN-1:0]           o_ram_wr_data,
   input  logic [p_WORD_LEN-1:0]           i_ram_rd_data,
   input  logic [p_IN_NUM*p_WORD_LEN-1:0]  i_in,
   output logic [p_OUT_NUM*p_WORD_LEN-1:0] o_out,
   output logic [p_OUT_NUM-1:0]            o_out_stb,
   output logic                            o_irq
);

   localparam int W = p_WORD_LEN;
`ifdef MMIO_TIMER_EN
   localparam logic TMR_EN = 1'b1;
`else
   localparam logic TMR_EN = 1'b0;
`endif

   // Reset asserts asynchronously but is released only on a clock edge.
   logic [1:0] rst_sync_q;
   logic       rst_n_int;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) rst_sync_q <= 2'b00;
      else          rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n_int = rst_sync_q[1];

   dec_t dec;
   assign dec = mmio_decode(i_addr, p_DATA_ADDR_LEN, p_OUT_NUM, p_IN_NUM, TMR_EN);

   assign o_ram_addr    = i_addr[p_DATA_ADDR_LEN-1:0];
   assign o_ram_wr_data = i_wr_data;
   assign o_ram_wr_en   = i_wr_en && (dec.sel == SEL_RAM);

   logic [W-1:0]         out_q [p_OUT_NUM];
   logic [p_OUT_NUM-1:0] stb_q, stb_d;

   always_comb begin
      stb_d = '0;
      for (int k = 0; k < p_OUT_NUM; k++)
         stb_d[k] = i_wr_en && (dec.sel == SEL_OUT) && (dec.idx == 3'(k));
   end

   always_ff @(posedge i_clk or negedge rst_n_int) begin
      if (!rst_n_int) begin
         stb_q <= '0;
         for (int k = 0; k < p_OUT_NUM; k++) out_q[k] <= '0;
      end else begin
         stb_q <= stb_d;
         for (int k = 0; k < p_OUT_NUM; k++)
            if (stb_d[k]) out_q[k] <= i_wr_data;
      end
   end

   for (genvar k = 0; k < p_OUT_NUM; k++) begin : g_out
      assign o_out[k*W +: W] = out_q[k];
   end
   assign o_out_stb = stb_q;

   logic [W-1:0] sync1_q [p_IN_NUM];
   logic [W-1:0] sync2_q [p_IN_NUM];

   always_ff @(posedge i_clk or negedge rst_n_int) begin
      if (!rst_n_int) begin
         for (int k = 0; k < p_IN_NUM; k++) begin
            sync1_q[k] <= '0;
            sync2_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < p_IN_NUM; k++) begin
            sync1_q[k] <= i_in[k*W +: W];
            sync2_q[k] <= sync1_q[k];
         end
      end
   end

   // Registering the select lines RAM-region reads up with the RAM's own latency.
   sel_e       sel_q;
   logic [2:0] idx_q;

   always_ff @(posedge i_clk or negedge rst_n_int) begin
      if (!rst_n_int) begin
         sel_q <= SEL_NONE;
         idx_q <= '0;
      end else begin
         sel_q <= dec.sel;
         idx_q <= dec.idx;
      end
   end

   logic [W-1:0] tmr_rd;

`ifdef MMIO_TIMER_EN
   logic [15:0] tmr_cnt, tmr_cmp, tmr_rd16;
   logic        tmr_match;
   logic        tmr_wr;

   assign tmr_wr = i_wr_en && (dec.sel == SEL_TMR);

   mmio_timer u_timer (
      .i_clk     (i_clk),
      .i_rst_n   (rst_n_int),
      .i_wr_cnt  (tmr_wr && (dec.idx == 3'd0)),
      .i_wr_cmp  (tmr_wr && (dec.idx == 3'd1)),
      .i_wr_stat (tmr_wr && (dec.idx == 3'd2)),
      .i_wr_data (16'(i_wr_data)),
      .o_cnt     (tmr_cnt),
      .o_cmp     (tmr_cmp),
      .o_match   (tmr_match)
   );

   always_comb begin
      tmr_rd16 = 16'h0000;
      case (idx_q)
         3'd0:    tmr_rd16 = tmr_cnt;
         3'd1:    tmr_rd16 = tmr_cmp;
         3'd2:    tmr_rd16 = {15'd0, tmr_match};
         default: tmr_rd16 = 16'h0000;
      endcase
   end

   assign tmr_rd = W'(tmr_rd16);
   assign o_irq  = tmr_match;
`else
   assign tmr_rd = '0;
   assign o_irq  = 1'b0;
`endif

   always_comb begin
      o_rd_data = '0;
      case (sel_q)
         SEL_RAM: o_rd_data = i_ram_rd_data;
         SEL_OUT: begin
            for (int k = 0; k < p_OUT_NUM; k++)
               if (idx_q == 3'(k)) o_rd_data = out_q[k];
         end
         SEL_IN: begin
            for (int k = 0; k < p_IN_NUM; k++)
               if (idx_q == 3'(k)) o_rd_data = sync2_q[k];
         end
         SEL_TMR: o_rd_data = tmr_rd;
         default: o_rd_data = '0;
      endcase
   end

endmodule

// File: tb/tb_mmio_bus.sv
// Scoreboard bench for mmio_bus: reads push expectations, a negedge monitor
// pops them one cycle later; control outputs are checked directly.
module tb_mmio_bus;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] addr;
   logic [15:0] wr_data;
   logic        wr_en;
   logic [15:0] rd_data;
   logic [9:0]  ram_addr;
   logic        ram_we;
   logic [15:0] ram_wd;
   logic [15:0] ram_rd;
   logic [31:0] in_bus;
   logic [63:0] out_bus;
   logic [3:0]  out_stb;
   logic        irq;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string       tag;
      logic [15:0] exp;
   } sb_t;
   sb_t  sb[$];
   logic drv_rd = 1'b0;
   logic issued = 1'b0;

   logic [15:0] mem [1024];

   always #5 clk = ~clk;

   mmio_bus dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_addr        (addr),
      .i_wr_data     (wr_data),
      .i_wr_en       (wr_en),
      .o_rd_data     (rd_data),
      .o_ram_addr    (ram_addr),
      .o_ram_wr_en   (ram_we),
      .o_ram_wr_data (ram_wd),
      .i_ram_rd_data (ram_rd),
      .i_in          (in_bus),
      .o_out         (out_bus),
      .o_out_stb     (out_stb),
      .o_irq         (irq)
   );

   // Synchronous RAM with one-cycle read latency.
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wd;
      ram_rd <= mem[ram_addr];
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   always @(posedge clk) issued <= drv_rd;

   always @(negedge clk) begin
      if (issued) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 64'd1, 64'd0);
         end else begin
            sb_t e;
            e = sb.pop_front();
            chk(e.tag, {48'd0, rd_data}, {48'd0, e.exp});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      addr   = 16'h8000;
      wr_en  = 1'b0;
      drv_rd = 1'b0;
      step();
   endtask

   task automatic bus_rd(input logic [15:0] a, input logic [15:0] exp, input string tag);
      addr   = a;
      wr_en  = 1'b0;
      drv_rd = 1'b1;
      sb.push_back('{tag, exp});
      step();
      drv_rd = 1'b0;
   endtask

   task automatic bus_wr(input logic [15:0] a, input logic [15:0] d, input logic exp_we,
                         input string tag);
      addr    = a;
      wr_data = d;
      wr_en   = 1'b1;
      drv_rd  = 1'b0;
      #1;
      chk(tag, {63'd0, ram_we}, {63'd0, exp_we});
      step();
      wr_en = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
      rst_n   = 1'b0;
      addr    = 16'h8000;
      wr_data = 16'h0000;
      wr_en   = 1'b0;
      in_bus  = 32'h0;
      repeat (3) step();
      chk("rst_out", out_bus, 64'h0);
      chk("rst_stb", {60'd0, out_stb}, 64'h0);
      chk("rst_irq", {63'd0, irq}, 64'h0);
      chk("rst_rd", {48'd0, rd_data}, 64'h0);
      rst_n = 1'b1;
      repeat (4) step();

      bus_rd(16'hFFFF, 16'h0000, "rd_out0_init");
      bus_rd(16'hFFF7, 16'h0000, "rd_in0_init");
      bus_rd(16'h1234, 16'h0000, "rd_unmapped");
      idle();
      chk("irq_init", {63'd0, irq}, 64'h0);

      bus_wr(16'hFFFF, 16'hBEEF, 1'b0, "we_out0");
      chk("out0_val", {48'd0, out_bus[15:0]}, 64'hBEEF);
      chk("out0_stb", {60'd0, out_stb}, 64'h1);
      idle();
      chk("out0_stb_drop", {60'd0, out_stb}, 64'h0);
      bus_rd(16'hFFFF, 16'hBEEF, "rd_out0");

      bus_wr(16'hFFFE, 16'h1234, 1'b0, "we_out1");
      bus_rd(16'hFFFE, 16'h1234, "rd_out1_b2b");
      bus_wr(16'hFFFD, 16'h0001, 1'b0, "we_out2a");
      chk("stb2_first", {60'd0, out_stb}, 64'h4);
      bus_wr(16'hFFFD, 16'h0002, 1'b0, "we_out2b");
      chk("stb2_second", {60'd0, out_stb}, 64'h4);
      chk("out2_val", {48'd0, out_bus[47:32]}, 64'h0002);
      idle();
      chk("stb2_drop", {60'd0, out_stb}, 64'h0);

      addr    = 16'h0005;
      wr_data = 16'h00AA;
      wr_en   = 1'b1;
      #1;
      chk("ram_addr5", {54'd0, ram_addr}, 64'h5);
      step();
      wr_en = 1'b0;
      chk("ram_mem5", {48'd0, mem[5]}, 64'h00AA);
      bus_rd(16'h0005, 16'h00AA, "rd_ram5");
      bus_wr(16'h0400, 16'h7777, 1'b0, "we_0400");
      bus_rd(16'h0400, 16'h0000, "rd_0400");
      bus_wr(16'h03FF, 16'h3C3C, 1'b1, "we_ram_top");
      bus_rd(16'h03FF, 16'h3C3C, "rd_ram_top");
      bus_wr(16'hFFF7, 16'h9999, 1'b0, "we_in0");

      in_bus = {16'hC3C3, 16'h5A5A};
      bus_rd(16'hFFF7, 16'h0000, "rd_in0_early");
      idle();
      bus_rd(16'hFFF7, 16'h5A5A, "rd_in0_sync");
      bus_rd(16'hFFF6, 16'hC3C3, "rd_in1_sync");
      idle();

`ifdef MMIO_TIMER_EN
      bus_wr(16'hFFE2, 16'h0001, 1'b0, "we_stat_pre");
      bus_wr(16'hFFE0, 16'hFFFE, 1'b0, "we_cnt");
      bus_wr(16'hFFE1, 16'h0001, 1'b0, "we_cmp");
      chk("irq_load1", {63'd0, irq}, 64'h0);
      idle();
      chk("irq_load2", {63'd0, irq}, 64'h0);
      idle();
      chk("irq_match", {63'd0, irq}, 64'h1);
      bus_rd(16'hFFE2, 16'h0001, "rd_stat");
      bus_rd(16'hFFE0, 16'h0003, "rd_cnt");
      bus_wr(16'hFFE2, 16'h0001, 1'b0, "we_stat_clr");
      chk("irq_clr", {63'd0, irq}, 64'h0);
      bus_wr(16'hFFE1, 16'h0100, 1'b0, "we_cmp2");
      bus_wr(16'hFFE0, 16'h00FE, 1'b0, "we_cnt2");
      idle();
      chk("irq_pre_race", {63'd0, irq}, 64'h0);
      bus_wr(16'hFFE2, 16'h0001, 1'b0, "we_stat_race");
      chk("irq_set_wins", {63'd0, irq}, 64'h1);
      bus_rd(16'hFFE1, 16'h0100, "rd_cmp");
`else
      bus_rd(16'hFFE0, 16'h0000, "rd_cnt_off");
      bus_wr(16'hFFE1, 16'h0005, 1'b0, "we_cmp_off");
      bus_rd(16'hFFE1, 16'h0000, "rd_cmp_off");
      chk("irq_off", {63'd0, irq}, 64'h0);
`endif

      bus_wr(16'hFFFE, 16'h1111, 1'b0, "we_out1_rst");
      chk("out1_pre_rst", {48'd0, out_bus[31:16]}, 64'h1111);
      addr   = 16'hFFFE;
      wr_en  = 1'b0;
      drv_rd = 1'b1;
      sb.push_back('{"rd_pending_rst", 16'h0000});
      @(posedge clk);
      #2;
      rst_n  = 1'b0;
      drv_rd = 1'b0;
      #1;
      chk("rst_async_out", out_bus, 64'h0);
      chk("rst_async_stb", {60'd0, out_stb}, 64'h0);
      chk("rst_async_irq", {63'd0, irq}, 64'h0);
      repeat (3) step();
      rst_n = 1'b1;
      repeat (4) step();
      bus_rd(16'hFFFE, 16'h0000, "rd_out1_post_rst");
      idle();
      idle();
      chk("sb_empty", {32'd0, 32'(sb.size())}, 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mmio_bus.md
# mmio_bus

Memory-mapped data-bus controller between the RiSC-16 core's data port and the data RAM. Decodes each core access into RAM, a bank of parametrised output registers (word 0 at 0xFFFF, the legacy display address), synchronised input ports and an optional cycle timer. It realigns read data to the synchronous RAM's one-cycle latency, so the core always sees one uniform read latency.

## Interface
- p_WORD_LEN, 16, data word width (address is always 16 bits)
- p_DATA_ADDR_LEN, 10, RAM address bits; legal range 1..15
- p_OUT_NUM, 4, output registers; legal range 1..8
- p_IN_NUM, 2, input ports; legal range 1..8

- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_addr  in  16  core data address
- i_wr_data  in  p_WORD_LEN  core write data
- i_wr_en  in  1  core write enable
- o_rd_data  out  p_WORD_LEN  read data to core
- o_ram_addr  out  p_DATA_ADDR_LEN  = i_addr[p_DATA_ADDR_LEN-1:0]
- o_ram_wr_en  out  1  i_wr_en && RAM hit
- o_ram_wr_data  out  p_WORD_LEN  = i_wr_data
- i_ram_rd_data  in  p_WORD_LEN  RAM read data, one cycle after address
- i_in  in  p_IN_NUM*p_WORD_LEN  asynchronous input ports
- o_out  out  p_OUT_NUM*p_WORD_LEN  output registers
- o_out_stb  out  p_OUT_NUM  one-cycle write pulse per output
- o_irq  out  1  timer match flag (0 when timer compiled out)

## Operation
- Address map:
  - RAM: addr < 2**p_DATA_ADDR_LEN.
  - OUT[k]: 0xFFFF-k.
  - IN[k]: 0xFFF7-k, read-only.
  - Timer: CNT 0xFFE0, CMP 0xFFE1, STAT 0xFFE2 (bit0 = match).
  - Everything else is unmapped.
- Writes are sampled at the rising edge with i_wr_en. OUT[k] <= i_wr_data, and o_out_stb[k] is 1 for the following cycle.
- Writes to IN addresses or unmapped addresses are ignored. RAM receives no write for any non-RAM address.
- Reads: the region select and the index are registered each cycle.
  - o_rd_data is a combinational mux of the registered select: RAM → i_ram_rd_data; OUT/IN/timer → the register value; unmapped → 0.
  - OUT registers read back their stored value.
- Each input port passes through a two-flop synchroniser. Reads return the synchronised value.
- Reset (asynchronous assert, synchronous release):
  - o_out, o_out_stb, o_irq, synchronisers and registered select all go to 0.
  - With select SEL_NONE, o_rd_data = 0.

## Timing
- Read latency: 1 cycle. The data for the address presented in cycle N is on o_rd_data in cycle N+1, for every region.
- Write then read of the same OUT address in consecutive cycles returns the new value.
- o_out changes 1 cycle after the write edge. Back-to-back writes to the same OUT keep o_out_stb high for two cycles.
- i_in to readable value: 2 edges of synchroniser latency, plus the 1-cycle read latency.
- Reset asserted mid-access: the pending read returns 0 and no write occurs.

## Configuration
- MMIO_TIMER_EN defined:
  - A 16-bit CNT register increments by 1 every cycle and wraps from 0xFFFF to 0.
  - A write to CNT loads the written value; CNT increments from that value on the next edge.
  - CMP is read/write and resets to 0xFFFF.
  - When CNT == CMP, STAT.match is set. STAT.match is sticky and o_irq = STAT.match.
  - Writing 1 to STAT bit0 clears match. If a set and a clear occur in the same cycle, the set wins.
- MMIO_TIMER_EN undefined: the timer addresses decode as unmapped (read 0, writes ignored) and o_irq is tied to 0.

## Structure
- Package mmio_pkg holds:
  - Address constants: OUT_BASE 0xFFFF, IN_BASE 0xFFF7, TMR_CNT/CMP/STAT.
  - Select enum: SEL_NONE, SEL_RAM, SEL_OUT, SEL_IN, SEL_TMR.
- Sub-module mmio_timer holds the CNT/CMP/STAT registers and match logic. It is instantiated only under MMIO_TIMER_EN.

## Test plan
- Reset, then read 0xFFFF, 0xFFF7 and 0x1234 → every o_rd_data is 0. o_irq = 0.
- Write 0xBEEF to 0xFFFF → OUT[0] = 0xBEEF one cycle later, o_out_stb[0] high for exactly 1 cycle, RAM write enable never asserted. Read 0xFFFF back → 0xBEEF.
- Write 0x00AA to RAM addr 5, then read addr 5 → o_ram_wr_en pulses with addr 5; the read returns 0x00AA on cycle N+1. Write and read 0x0400 (with p_DATA_ADDR_LEN=10) → no RAM write, read 0.
- Drive i_in[0] = 0x5A5A → a read of 0xFFF7 started 2 cycles later returns 0x5A5A; a read started earlier returns the old value.
- MMIO_TIMER_EN: write CNT = 0xFFFE, CMP = 0x0001 → CNT wraps through 0; match and o_irq set 3 cycles after the load. Write 1 to STAT → o_irq = 0. Clear on the match cycle → o_irq stays 1.
- Assert i_rst_n low mid-stream while OUT[1] = 0x1111 → o_out goes to 0 immediately (asynchronously). The pending read returns 0.
